// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM stage and the data memory.
// The MEM stage drives the request side; memory returns rdata/ack.
interface mem_stage_ctrl_if;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;
  logic       dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: issues data-memory accesses from EX/MEM, stalls upstream
// until ack or timeout, and loads the MEM/WB register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        alu_result_in,
  input  logic [7:0]        rb_in,
  input  logic [7:0]        addr_in,
  input  logic [1:0]        rd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              flag_write_in,
  mem_stage_ctrl_if.master  dmem,
  output logic              mem_stall,
  output logic              bus_err,
  output logic [7:0]        wb_data_out,
  output logic [1:0]        wb_rd_out,
  output logic              wb_reg_write_out,
  output logic              wb_flag_write_out
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_flushed;
  logic       r_req;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_bus_err;
  logic [7:0] r_wb_data;
  logic [1:0] r_wb_rd;
  logic       r_wb_rw;
  logic       r_wb_fw;

  logic w_memop;
  logic w_issue;
  logic w_timeout;
  logic w_squash;

  assign w_memop   = mem_read_in | mem_write_in;
  assign w_issue   = (r_state == IDLE) & w_memop & ~flush;
  assign w_timeout = (r_state == WAIT) & ~dmem.dmem_ack
                   & (r_wait_cnt == 8'(TIMEOUT - 1));
  // A flush seen in the ack cycle itself squashes too.
  assign w_squash  = r_flushed | flush;

  assign mem_stall = rst & (w_issue |
    ((r_state == WAIT) & ~dmem.dmem_ack & ~w_timeout));

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign bus_err           = r_bus_err;
  assign wb_data_out       = r_wb_data;
  assign wb_rd_out         = r_wb_rd;
  assign wb_reg_write_out  = r_wb_rw;
  assign wb_flag_write_out = r_wb_fw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      r_flushed  <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 8'd0;
      r_wdata    <= 8'd0;
      r_bus_err  <= 1'b0;
      r_wb_data  <= 8'd0;
      r_wb_rd    <= 2'd0;
      r_wb_rw    <= 1'b0;
      r_wb_fw    <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      r_wb_data <= 8'd0;
      r_wb_rd   <= 2'd0;
      r_wb_rw   <= 1'b0;
      r_wb_fw   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state    <= WAIT;
            r_req      <= 1'b1;
            r_we       <= mem_write_in;
            r_addr     <= addr_in;
            r_wdata    <= rb_in;
            r_wait_cnt <= 8'd0;
          end else if (!flush) begin
            r_wb_data <= alu_result_in;
            r_wb_rd   <= rd_in;
            r_wb_rw   <= reg_write_in;
            r_wb_fw   <= flag_write_in;
          end
        end
        WAIT: begin
          unique case (1'b1)
            dmem.dmem_ack: begin
              r_state   <= IDLE;
              r_req     <= 1'b0;
              r_flushed <= 1'b0;
              if (!w_squash) begin
                r_wb_data <= r_we ? alu_result_in
                                  : dmem.dmem_rdata;
                r_wb_rd   <= rd_in;
                r_wb_rw   <= reg_write_in;
                r_wb_fw   <= flag_write_in;
              end
            end
            w_timeout: begin
              r_state   <= IDLE;
              r_req     <= 1'b0;
              r_flushed <= 1'b0;
              r_bus_err <= 1'b1;
            end
            default: begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
              if (flush) r_flushed <= 1'b1;
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
